// File: rtl/id_stage_pipe_pkg.sv
// rtl/id_stage_pipe_pkg.sv - shared MIPS opcode/function constants for the decode stage
package id_stage_pipe_pkg;

  typedef enum logic [5:0] {
    OP_R_FORM = 6'h00,
    OP_J      = 6'h02,
    OP_JAL    = 6'h03,
    OP_BEQ    = 6'h04,
    OP_BNE    = 6'h05,
    OP_ADDI   = 6'h08,
    OP_ADDIU  = 6'h09,
    OP_SLTI   = 6'h0A,
    OP_SLTIU  = 6'h0B,
    OP_ANDI   = 6'h0C,
    OP_ORI    = 6'h0D,
    OP_XORI   = 6'h0E,
    OP_LUI    = 6'h0F,
    OP_LW     = 6'h23,
    OP_SW     = 6'h2B
  } opcode_e;

  typedef enum logic [5:0] {
    FN_JR    = 6'h08,
    FN_JALR  = 6'h09,
    FN_MTHI  = 6'h11,
    FN_MTLO  = 6'h13,
    FN_MULT  = 6'h18,
    FN_MULTU = 6'h19,
    FN_DIV   = 6'h1A,
    FN_DIVU  = 6'h1B
  } func_e;

  // R-form ops that only touch HI/LO or the PC never write a GPR
  function automatic logic r_form_writes(input logic [5:0] f);
    case (func_e'(f))
      FN_JR, FN_MTHI, FN_MTLO, FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: r_form_writes = 1'b0;
      default: r_form_writes = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// rtl/id_stage_pipe_if.sv - IF/ID input, WB write-back and ID/EX output signal bundle
interface id_stage_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADR_W  = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       Ins;
  logic              flush;
  logic              wb_we;
  logic [ADR_W-1:0]  wb_adr;
  logic [DATA_W-1:0] wb_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] Rdata1;
  logic [DATA_W-1:0] Rdata2;
  logic [DATA_W-1:0] Ed32;
  logic [ADR_W-1:0]  Wadr;
  logic              WE;
  logic [5:0]        op_q;
  logic [5:0]        func_q;

  modport master (
    output in_valid, Ins, flush, wb_we, wb_adr, wb_data, out_ready,
    input  in_ready, out_valid, Rdata1, Rdata2, Ed32, Wadr, WE, op_q, func_q
  );

  modport slave (
    input  in_valid, Ins, flush, wb_we, wb_adr, wb_data, out_ready,
    output in_ready, out_valid, Rdata1, Rdata2, Ed32, Wadr, WE, op_q, func_q
  );
endinterface

// File: rtl/id_stage_pipe_regfile_2r1w.sv
// rtl/id_stage_pipe_regfile_2r1w.sv - 2-read 1-write register file, async read, sync write
module regfile_2r1w #(
  parameter int DATA_W   = 32,
  parameter int REG_NUM  = 32,
  parameter int ZERO_REG = 1,
  localparam int ADR_W   = $clog2(REG_NUM)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADR_W-1:0]  ra1,
  input  logic [ADR_W-1:0]  ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADR_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd
);
  logic [DATA_W-1:0] mem [REG_NUM];
  logic              drop;

  assign drop = (ZERO_REG != 0) && (wa == '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < REG_NUM; i++) mem[i] <= '0;
    end else if (we && !drop) begin
      mem[wa] <= wd;
    end
  end

  assign rd1 = ((ZERO_REG != 0) && (ra1 == '0)) ? '0 : mem[ra1];
  assign rd2 = ((ZERO_REG != 0) && (ra2 == '0)) ? '0 : mem[ra2];
endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - MIPS decode stage with ID/EX register; ID_WB_BYPASS_EN enables WB forwarding
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_NUM  = 32,
  parameter int ZERO_REG = 1
) (
  input logic           CLK,
  input logic           RST,
  id_stage_pipe_if.slave bus
);
  localparam int ADR_W = $clog2(REG_NUM);

  opcode_e           op;
  logic [5:0]        func;
  logic [15:0]       imm;
  logic [ADR_W-1:0]  rs, rt, rd;
  logic [ADR_W-1:0]  dec_wadr;
  logic              dec_we;
  logic [DATA_W-1:0] dec_ed;
  logic [DATA_W-1:0] rf_rd1, rf_rd2, opnd1, opnd2;
  logic              capture;

  logic              valid_q;
  logic [DATA_W-1:0] rdata1_q, rdata2_q, ed_q;
  logic [ADR_W-1:0]  wadr_q;
  logic              we_q;
  logic [5:0]        op_q, func_q;

  assign op   = opcode_e'(bus.Ins[31:26]);
  assign func = bus.Ins[5:0];
  assign imm  = bus.Ins[15:0];
  assign rs   = bus.Ins[21 +: ADR_W];
  assign rt   = bus.Ins[16 +: ADR_W];
  assign rd   = bus.Ins[11 +: ADR_W];

  regfile_2r1w #(
    .DATA_W  (DATA_W),
    .REG_NUM (REG_NUM),
    .ZERO_REG(ZERO_REG)
  ) u_rf (
    .CLK(CLK),
    .RST(RST),
    .ra1(rs),
    .ra2(rt),
    .rd1(rf_rd1),
    .rd2(rf_rd2),
    .we (bus.wb_we),
    .wa (bus.wb_adr),
    .wd (bus.wb_data)
  );

  always_comb begin
    dec_wadr = rt;
    dec_we   = 1'b0;
    dec_ed   = DATA_W'(imm);
    case (op)
      OP_R_FORM: begin
        dec_wadr = rd;
        dec_we   = r_form_writes(func);
      end
      OP_JAL: begin
        dec_wadr = '1;
        dec_we   = 1'b1;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_LW: begin
        dec_we = 1'b1;
        dec_ed = DATA_W'($signed(imm));
      end
      OP_SW, OP_BEQ, OP_BNE: dec_ed = DATA_W'($signed(imm));
      OP_ANDI, OP_ORI, OP_XORI: dec_we = 1'b1;
      OP_LUI: begin
        dec_we = 1'b1;
        if (DATA_W == 32) dec_ed = DATA_W'(imm) << 16;
      end
      default: ;
    endcase
    if ((ZERO_REG != 0) && (dec_wadr == '0)) dec_we = 1'b0;
  end

`ifdef ID_WB_BYPASS_EN
  // Forward a same-cycle write so the hazard unit needs no extra stall
  always_comb begin
    opnd1 = rf_rd1;
    opnd2 = rf_rd2;
    if (bus.wb_we && (bus.wb_adr == rs) && !((ZERO_REG != 0) && (rs == '0))) opnd1 = bus.wb_data;
    if (bus.wb_we && (bus.wb_adr == rt) && !((ZERO_REG != 0) && (rt == '0))) opnd2 = bus.wb_data;
  end
`else
  assign opnd1 = rf_rd1;
  assign opnd2 = rf_rd2;
`endif

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      valid_q  <= 1'b0;
      rdata1_q <= '0;
      rdata2_q <= '0;
      ed_q     <= '0;
      wadr_q   <= '0;
      we_q     <= 1'b0;
      op_q     <= '0;
      func_q   <= '0;
    end else begin
      if (capture) begin
        rdata1_q <= opnd1;
        rdata2_q <= opnd2;
        ed_q     <= dec_ed;
        wadr_q   <= dec_wadr;
        we_q     <= dec_we && !bus.flush;
        op_q     <= bus.Ins[31:26];
        func_q   <= func;
      end
      // Flush kills the slot even when a new instruction lands in it
      if (bus.flush) begin
        valid_q <= 1'b0;
        we_q    <= 1'b0;
      end else if (capture) begin
        valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.Rdata1    = rdata1_q;
  assign bus.Rdata2    = rdata2_q;
  assign bus.Ed32      = ed_q;
  assign bus.Wadr      = wadr_q;
  assign bus.WE        = we_q;
  assign bus.op_q      = op_q;
  assign bus.func_q    = func_q;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed vector bench for id_stage_pipe
module tb_id_stage_pipe;
  localparam int DW = 32;
  localparam int RN = 32;
  localparam int AW = 5;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 CLK = ~CLK;

  id_stage_pipe_if #(.DATA_W(DW), .ADR_W(AW)) bus ();

  id_stage_pipe #(.DATA_W(DW), .REG_NUM(RN), .ZERO_REG(1)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] ed;
    logic [4:0]  wadr;
    logic        we;
    logic [5:0]  op;
    logic [5:0]  func;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic chk_vec(input int idx, input vec_t v);
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, ".out_valid"}, 64'(bus.out_valid), 64'(1'b1));
    chk({t, ".Rdata1"}, 64'(bus.Rdata1), 64'(v.rd1));
    chk({t, ".Rdata2"}, 64'(bus.Rdata2), 64'(v.rd2));
    chk({t, ".Ed32"}, 64'(bus.Ed32), 64'(v.ed));
    chk({t, ".Wadr"}, 64'(bus.Wadr), 64'(v.wadr));
    chk({t, ".WE"}, 64'(bus.WE), 64'(v.we));
    chk({t, ".op_q"}, 64'(bus.op_q), 64'(v.op));
    chk({t, ".func_q"}, 64'(bus.func_q), 64'(v.func));
  endtask

  task automatic drive(input logic [31:0] ins, input logic vld);
    bus.Ins      = ins;
    bus.in_valid = vld;
  endtask

  task automatic wb_write(input logic [4:0] adr, input logic [31:0] data);
    @(negedge CLK);
    bus.wb_we   = 1'b1;
    bus.wb_adr  = adr;
    bus.wb_data = data;
    @(negedge CLK);
    bus.wb_we   = 1'b0;
  endtask

  initial begin
    logic [31:0] exp_byp;

    vecs[0]  = '{i_ins(6'h08, 5, 6, 16'hFFFF), 32'h1234, 32'h0, 32'hFFFF_FFFF, 5'd6, 1'b1, 6'h08, 6'h3F};
    vecs[1]  = '{i_ins(6'h0D, 3, 2, 16'h8000), 32'h33, 32'h0, 32'h0000_8000, 5'd2, 1'b1, 6'h0D, 6'h00};
    vecs[2]  = '{r_ins(5, 7, 10, 6'h18), 32'h1234, 32'hAAAA_0007, 32'h5018, 5'd10, 1'b0, 6'h00, 6'h18};
    vecs[3]  = '{r_ins(3, 0, 9, 6'h09), 32'h33, 32'h0, 32'h4809, 5'd9, 1'b1, 6'h00, 6'h09};
    vecs[4]  = '{{6'h03, 26'h10}, 32'h0, 32'h0, 32'h10, 5'd31, 1'b1, 6'h03, 6'h10};
    vecs[5]  = '{i_ins(6'h0F, 0, 4, 16'hBEEF), 32'h0, 32'h0, 32'hBEEF_0000, 5'd4, 1'b1, 6'h0F, 6'h2F};
    vecs[6]  = '{i_ins(6'h2B, 5, 7, 16'h8004), 32'h1234, 32'hAAAA_0007, 32'hFFFF_8004, 5'd7, 1'b0, 6'h2B, 6'h04};
    vecs[7]  = '{i_ins(6'h23, 3, 0, 16'h0004), 32'h33, 32'h0, 32'h4, 5'd0, 1'b0, 6'h23, 6'h04};
    vecs[8]  = '{r_ins(5, 3, 8, 6'h20), 32'h1234, 32'h33, 32'h4020, 5'd8, 1'b1, 6'h00, 6'h20};
    vecs[9]  = '{r_ins(5, 0, 0, 6'h08), 32'h1234, 32'h0, 32'h8, 5'd0, 1'b0, 6'h00, 6'h08};
    vecs[10] = '{i_ins(6'h04, 3, 5, 16'hFFFE), 32'h33, 32'h1234, 32'hFFFF_FFFE, 5'd5, 1'b0, 6'h04, 6'h3E};
    vecs[11] = '{i_ins(6'h0C, 0, 1, 16'hF0F0), 32'h0, 32'h0, 32'hF0F0, 5'd1, 1'b1, 6'h0C, 6'h30};

    bus.in_valid = 1'b0;
    bus.Ins      = '0;
    bus.flush    = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_adr   = '0;
    bus.wb_data  = '0;
    bus.out_ready = 1'b1;

    #2;
    chk("rst.out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst.Rdata1", 64'(bus.Rdata1), 64'(0));
    chk("rst.Ed32", 64'(bus.Ed32), 64'(0));
    chk("rst.WE", 64'(bus.WE), 64'(0));
    chk("rst.in_ready", 64'(bus.in_ready), 64'(1));
    @(negedge CLK);
    RST = 1'b0;

    wb_write(5, 32'h1234);
    wb_write(3, 32'h33);
    wb_write(7, 32'hAAAA_0007);

    // Back-to-back table: one instruction per cycle, ready always high
    @(negedge CLK);
    drive(vecs[0].ins, 1'b1);
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      chk_vec(i, vecs[i]);
      if (i < 11) drive(vecs[i+1].ins, 1'b1);
      else drive('0, 1'b0);
    end
    @(negedge CLK);
    chk("drain.out_valid", 64'(bus.out_valid), 64'(0));

    // Stall with a pending instruction, then release
    drive(i_ins(6'h0D, 3, 2, 16'h8000), 1'b1);
    @(negedge CLK);
    chk("stall.a_Ed32", 64'(bus.Ed32), 64'(32'h8000));
    drive(i_ins(6'h08, 5, 6, 16'hFFFF), 1'b1);
    bus.out_ready = 1'b0;
    #1 chk("stall.in_ready", 64'(bus.in_ready), 64'(0));
    @(negedge CLK);
    chk("stall.out_valid", 64'(bus.out_valid), 64'(1));
    chk("stall.hold_Ed32", 64'(bus.Ed32), 64'(32'h8000));
    chk("stall.hold_Wadr", 64'(bus.Wadr), 64'(2));
    bus.out_ready = 1'b1;
    #1 chk("release.in_ready", 64'(bus.in_ready), 64'(1));
    @(negedge CLK);
    chk("release.out_valid", 64'(bus.out_valid), 64'(1));
    chk("release.Ed32", 64'(bus.Ed32), 64'(32'hFFFF_FFFF));
    chk("release.Wadr", 64'(bus.Wadr), 64'(6));
    chk("release.Rdata1", 64'(bus.Rdata1), 64'(32'h1234));

    // Flush on the same edge as a JAL capture
    drive({6'h03, 26'h40}, 1'b1);
    bus.flush = 1'b1;
    @(negedge CLK);
    chk("flush.out_valid", 64'(bus.out_valid), 64'(0));
    chk("flush.WE", 64'(bus.WE), 64'(0));
    bus.flush = 1'b0;
    drive(i_ins(6'h08, 3, 4, 16'h0002), 1'b1);
    @(negedge CLK);
    chk("post_flush.out_valid", 64'(bus.out_valid), 64'(1));
    chk("post_flush.WE", 64'(bus.WE), 64'(1));
    chk("post_flush.Wadr", 64'(bus.Wadr), 64'(4));
    chk("post_flush.Rdata1", 64'(bus.Rdata1), 64'(32'h33));

    // Write-back to r7 on the same edge as reading r7
    bus.wb_we   = 1'b1;
    bus.wb_adr  = 5'd7;
    bus.wb_data = 32'hCAFE_0007;
    drive(i_ins(6'h08, 7, 5, 16'h0000), 1'b1);
`ifdef ID_WB_BYPASS_EN
    exp_byp = 32'hCAFE_0007;
`else
    exp_byp = 32'hAAAA_0007;
`endif
    @(negedge CLK);
    chk("same_cycle_wb.Rdata1", 64'(bus.Rdata1), 64'(exp_byp));
    chk("same_cycle_wb.Rdata2", 64'(bus.Rdata2), 64'(32'h1234));
    bus.wb_we = 1'b0;
    @(negedge CLK);
    chk("after_wb.Rdata1", 64'(bus.Rdata1), 64'(32'hCAFE_0007));

    // Writes to r0 are dropped
    bus.wb_we   = 1'b1;
    bus.wb_adr  = 5'd0;
    bus.wb_data = 32'hFFFF_FFFF;
    drive(i_ins(6'h08, 0, 7, 16'h0000), 1'b1);
    @(negedge CLK);
    chk("r0_same.Rdata1", 64'(bus.Rdata1), 64'(0));
    chk("r0_same.Rdata2", 64'(bus.Rdata2), 64'(32'hCAFE_0007));
    bus.wb_we = 1'b0;
    @(negedge CLK);
    chk("r0_after.Rdata1", 64'(bus.Rdata1), 64'(0));

    // Asynchronous reset between clock edges
    drive(i_ins(6'h08, 5, 6, 16'h1111), 1'b1);
    @(negedge CLK);
    chk("pre_rst.out_valid", 64'(bus.out_valid), 64'(1));
    drive('0, 1'b0);
    #3 RST = 1'b1;
    #1;
    chk("async_rst.out_valid", 64'(bus.out_valid), 64'(0));
    chk("async_rst.Rdata1", 64'(bus.Rdata1), 64'(0));
    chk("async_rst.Ed32", 64'(bus.Ed32), 64'(0));
    chk("async_rst.Wadr", 64'(bus.Wadr), 64'(0));
    chk("async_rst.op_q", 64'(bus.op_q), 64'(0));
    @(negedge CLK);
    RST = 1'b0;
    drive(i_ins(6'h08, 5, 3, 16'h0001), 1'b1);
    @(negedge CLK);
    chk("rf_cleared.Rdata1", 64'(bus.Rdata1), 64'(0));
    chk("rf_cleared.Rdata2", 64'(bus.Rdata2), 64'(0));
    chk("rf_cleared.Ed32", 64'(bus.Ed32), 64'(1));
    drive('0, 1'b0);
    @(negedge CLK);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
